rx_cfg_sequencer: RTL
=====================

RX_CFG_SEQUENCER -- requirements
Module: rx_cfg_sequencer

Interface
REQ-001 NUM_ENTRIES, 60, number of table entries (idx 0..NUM_ENTRIES-1) written per configuration run; legal range 1..64.
REQ-002 CLK_DIV, 4, clk cycles per sclk half-period; minimum 1.
REQ-003 GAP_CYCLES, 8, clk cycles cs_n is held high between consecutive frames; minimum 1.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 nrst  in  1  reset nrst, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a configuration run.
REQ-007 abort  in  1  terminates any run in progress.
REQ-008 idx  out  6  table index presented to the combinational config table.
REQ-009 addr  in  5  target register address returned by the table for idx.
REQ-010 data  in  8  register value returned by the table for idx.
REQ-011 cs_n  out  1  serial chip select, active-low.
REQ-012 sclk  out  1  serial clock, idle low.
REQ-013 sdata  out  1  serial data, MSB first.
REQ-014 busy  out  1  high while a run is in progress.
REQ-015 done  out  1  one-cycle pulse on successful completion of a run.

Function
REQ-016 States SHALL be IDLE, LOAD, SHIFT, GAP, DONE.
REQ-017 In IDLE, start=1 SHALL set idx=0 and move to LOAD next cycle; busy SHALL rise on that same edge.
REQ-018 start while not IDLE SHALL be ignored.
REQ-019 In LOAD (one cycle), the block SHALL capture frame = {1'b0, addr[4:0], 2'b00, data[7:0]} (16 bits) and enter SHIFT.
REQ-020 On SHIFT entry, cs_n SHALL go low and sdata SHALL present frame[15].
REQ-021 Per bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; sdata changes only on the cycle sclk falls, or on SHIFT entry.
REQ-022 After bit 0's high phase, sclk=0, cs_n=1 and sdata=0 SHALL take effect together on entering GAP; a frame occupies exactly 32*CLK_DIV cycles with cs_n low.
REQ-023 GAP SHALL last GAP_CYCLES cycles; then, if idx<NUM_ENTRIES-1, idx increments and the FSM enters LOAD, else it enters DONE.
REQ-024 DONE SHALL last one cycle with done=1, busy=0 on the following edge, and return to IDLE; idx SHALL return to 0.
REQ-025 Per-entry period SHALL be 1+32*CLK_DIV+GAP_CYCLES cycles (137 at defaults).
REQ-026 abort=1 in any non-IDLE state SHALL, on the next edge, force IDLE, cs_n=1, sclk=0, sdata=0, busy=0, idx=0, with no done pulse; abort and start in the same cycle: abort wins.
REQ-027 The idx counter SHALL not wrap: with NUM_ENTRIES=64, the run ends after idx=63.
REQ-028 addr/data SHALL be sampled only in LOAD; changes during SHIFT/GAP SHALL not affect the frame in flight.

Reset
REQ-029 nrst=0 on a clock edge SHALL force IDLE, cs_n=1, sclk=0, sdata=0, busy=0, done=0, idx=0 and clear the shift and divider counters, including mid-frame.
REQ-030 start SHALL be ignored while nrst=0.

Structure
REQ-031 Package rx_cfg_pkg SHALL hold the state enum, FRAME_W=16, WRITE_BIT=1'b0 and the frame field positions.
REQ-032 Serialisation (divider, bit counter, shift register) SHALL live in sub-module rx_cfg_spi_tx with load/busy handshake; the sequencer FSM owns idx and run control.

Verification
REQ-033 Defaults; table idx0=(0x1F,0x00), idx1=(0x00,0xF1), idx2=(0x01,0x54); pulse start -> frames 0x7C00, 0x00F1, 0x0454 captured at sclk rising edges, in order.
REQ-034 NUM_ENTRIES=3, defaults -> done pulses exactly 3*137+1 cycles after the start edge, busy falls on the next edge, and cs_n falls 3 times.
REQ-035 abort asserted on bit 7 of frame 1 -> next edge cs_n=1, sclk=0, busy=0, idx=0; no done; a fresh start then resends from idx 0.
REQ-036 nrst low for one cycle mid-GAP -> all outputs at reset values next edge; no further sclk edges until start.
REQ-037 start repulsed while busy, plus table data changed during SHIFT -> no restart, and the transmitted frame equals the LOAD-time value.
REQ-038 NUM_ENTRIES=64, CLK_DIV=1, GAP_CYCLES=1 -> 64 frames, the last idx=63, and no idx wrap before done.

Source files
------------

// File: rtl/rx_cfg_pkg.sv
// Shared types and frame layout for the RX config sequencer.
// Frame: write bit, 5-bit register address, 2 pad bits, 8-bit value.
package rx_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } state_t;

  localparam int   FRAME_W  = 16;
  localparam logic WRITE_BIT = 1'b0;
  localparam int   WR_POS   = 15;
  localparam int   ADDR_MSB = 14;
  localparam int   ADDR_LSB = 10;
  localparam int   DATA_MSB = 7;
  localparam int   DATA_LSB = 0;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [4:0] a,
    input logic [7:0] d
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[WR_POS] = WRITE_BIT;
    f[ADDR_MSB:ADDR_LSB] = a;
    f[DATA_MSB:DATA_LSB] = d;
    return f;
  endfunction

endpackage

// File: rtl/rx_cfg_spi_tx.sv
// Serialiser for one config frame: clock divider, bit counter, shifter.
// busy drops in the final cycle of a frame so the caller steps on the same edge.
module rx_cfg_spi_tx
  import rx_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               load,
  input  logic               clr,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               cs_n,
  output logic               sclk,
  output logic               sdata
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]      div;
  logic [3:0]         bits;
  logic [FRAME_W-2:0] sh;
  logic               active;
  logic               tick;
  logic               last;

  assign tick = (div == DW'(CLK_DIV - 1));
  assign last = active && sclk && tick
             && (bits == 4'(FRAME_W - 1));
  assign busy = active && !last;

  always_ff @(posedge clk) begin
    if (!nrst || clr) begin
      div    <= '0;
      bits   <= '0;
      sh     <= '0;
      active <= 1'b0;
      cs_n   <= 1'b1;
      sclk   <= 1'b0;
      sdata  <= 1'b0;
    end else if (load) begin
      div    <= '0;
      bits   <= '0;
      sh     <= frame[FRAME_W-2:0];
      active <= 1'b1;
      cs_n   <= 1'b0;
      sclk   <= 1'b0;
      sdata  <= frame[FRAME_W-1];
    end else if (active) begin
      if (!tick) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else if (last) begin
          active <= 1'b0;
          cs_n   <= 1'b1;
          sclk   <= 1'b0;
          sdata  <= 1'b0;
        end else begin
          sclk  <= 1'b0;
          bits  <= bits + 1'b1;
          sdata <= sh[FRAME_W-2];
          sh    <= {sh[FRAME_W-3:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/rx_cfg_sequencer.sv
// Walks the config table, sending one serial write frame per entry.
// Owns idx, run control and the busy/done status.
module rx_cfg_sequencer
  import rx_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 60,
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       abort,
  output logic [5:0] idx,
  input  logic [4:0] addr,
  input  logic [7:0] data,
  output logic       cs_n,
  output logic       sclk,
  output logic       sdata,
  output logic       busy,
  output logic       done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state;
  logic [GW-1:0]      gap;
  logic [FRAME_W-1:0] frame;
  logic               load;
  logic               kill;
  logic               tx_busy;

  assign frame = build_frame(addr, data);
  assign load  = (state == LOAD);
  assign kill  = abort && (state != IDLE);

  rx_cfg_spi_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .nrst  (nrst),
    .load  (load),
    .clr   (kill),
    .frame (frame),
    .busy  (tx_busy),
    .cs_n  (cs_n),
    .sclk  (sclk),
    .sdata (sdata)
  );

  always_ff @(posedge clk) begin
    if (!nrst || kill) begin
      state <= IDLE;
      idx   <= '0;
      gap   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort && !busy) begin
            state <= LOAD;
            idx   <= '0;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: state <= SHIFT;
        SHIFT: begin
          if (!tx_busy) begin
            state <= GAP;
            gap   <= '0;
          end
        end
        GAP: begin
          if (gap == GW'(GAP_CYCLES - 1)) begin
            if (idx == 6'(NUM_ENTRIES - 1)) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
          end else begin
            gap <= gap + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
